// File: rtl/rv2t_mem_arbiter_pkg.sv
// rv2t_mem_arbiter_pkg
// Shared definitions for the RV2T memory arbiter slice: bus widths,
// read-owner identifiers used to route returning read data, and the
// halt-handshake FSM state encodings.
package rv2t_mem_arbiter_pkg;

    // Word address width towards memory.
    localparam int MEM_ADDR_BITS = 16;
    // Data word width and the matching byte-lane count.
    localparam int XLEN          = 32;
    localparam int XLEN_BYTES    = XLEN / 8;

    // Who owns the read data that memory returns next cycle.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_OCD  = 2'd1,
        OWNER_CODE = 2'd2,
        OWNER_DATA = 2'd3
    } owner_e;

    // Core-traffic halt handshake states.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } arb_state_e;

    // A load/store with no byte lane enabled is a read.
    function automatic logic is_read_be(input logic [XLEN_BYTES-1:0] be);
        return (be == {XLEN_BYTES{1'b0}});
    endfunction

endpackage

// File: rtl/rv2t_mem_arbiter_if.sv
// rv2t_mem_arbiter_if
// Bundles the three requester ports (OCD, fetch, load/store), the shared
// read-return bus and the memory-side port of the RV2T arbiter.
//   slave  : the arbiter's view (requests in, grants/rvalid/memory out)
//   master : the environment's view (requesters and memory controller)
interface rv2t_mem_arbiter_if;
    import rv2t_mem_arbiter_pkg::*;

    // OCD (debug) requester and halt handshake
    logic                     ocd_req;
    logic                     ocd_we;
    logic [MEM_ADDR_BITS-1:0] ocd_addr;
    logic [XLEN-1:0]          ocd_wdata;
    logic                     ocd_halt;
    logic                     ocd_halt_ack;
    logic                     ocd_gnt;
    logic                     ocd_rvalid;

    // Instruction fetch requester
    logic                     code_req;
    logic [MEM_ADDR_BITS-1:0] code_addr;
    logic                     code_gnt;
    logic                     code_rvalid;

    // Data load/store requester
    logic                     data_req;
    logic [XLEN_BYTES-1:0]    data_be;
    logic [MEM_ADDR_BITS-1:0] data_addr;
    logic [XLEN-1:0]          data_wdata;
    logic                     data_gnt;
    logic                     data_rvalid;

    // Shared read-return word
    logic [XLEN-1:0]          rdata;

    // Memory controller port
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic [XLEN_BYTES-1:0]    mem_write_en;
    logic [XLEN-1:0]          mem_write_data;
    logic [XLEN-1:0]          mem_read_data;

    modport slave (
        input  ocd_req, ocd_we, ocd_addr, ocd_wdata, ocd_halt,
        output ocd_halt_ack, ocd_gnt, ocd_rvalid,
        input  code_req, code_addr,
        output code_gnt, code_rvalid,
        input  data_req, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid,
        output rdata,
        output mem_addr, mem_write_en, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output ocd_req, ocd_we, ocd_addr, ocd_wdata, ocd_halt,
        input  ocd_halt_ack, ocd_gnt, ocd_rvalid,
        output code_req, code_addr,
        input  code_gnt, code_rvalid,
        output data_req, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid,
        input  rdata,
        input  mem_addr, mem_write_en, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/rv2t_mem_arbiter_wait_counter.sv
// rv2t_mem_arbiter_wait_counter
// Saturating count of consecutive denied cycles for one core requester.
// Ports:
//   clk        : clock, rising edge
//   sync_reset : synchronous active-high reset
//   inc        : requester asked and was denied this cycle
//   clr        : requester was granted or is idle (wins over inc)
//   saturated  : count has reached MAX_WAIT; the requester is promoted
module rv2t_mem_arbiter_wait_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic inc,
    input  logic clr,
    output logic saturated
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             sat_s;

    // Saturation flag decoded from the counter register.
    always_comb begin
        sat_s = (cnt_r == CNT_W'(MAX_WAIT));
    end

    // Denied-cycle counter: clear beats increment, holds once saturated.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && !sat_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign saturated = sat_s;

endmodule

// File: rtl/rv2t_mem_arbiter.sv
// rv2t_mem_arbiter
// Arbitrates the single RV2T memory port between OCD, instruction fetch and
// data load/store. Grants are decided combinationally in the request cycle
// (one per cycle), the granted requester drives the memory port, and a read
// grant records its owner so the word memory returns one cycle later is
// flagged on that owner's rvalid. Fetch and data are normally ordered
// data > code, but a requester denied MAX_WAIT cycles in a row is promoted
// (data wins if both are promoted). OCD always outranks the core. An OCD
// halt request stops core grants, lets any outstanding read return and then
// acknowledges with ocd_halt_ack.
// Ports:
//   clk        : clock, rising edge
//   sync_reset : synchronous active-high reset; also masks rvalid/gnt/ack
//   bus        : requester, read-return and memory signals (slave modport)
module rv2t_mem_arbiter
    import rv2t_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              sync_reset,
    rv2t_mem_arbiter_if.slave bus
);

    arb_state_e               state_r;
    arb_state_e               state_nx_s;
    owner_e                   owner_r;
    owner_e                   owner_nx_s;
    owner_e                   win_s;

    logic                     run_s;
    logic                     core_en_s;
    logic                     halt_ack_s;

    logic                     ocd_gnt_s;
    logic                     code_gnt_s;
    logic                     data_gnt_s;

    logic                     code_sat_s;
    logic                     data_sat_s;
    logic                     code_inc_s;
    logic                     code_clr_s;
    logic                     data_inc_s;
    logic                     data_clr_s;

    logic [MEM_ADDR_BITS-1:0] mem_addr_s;
    logic [XLEN_BYTES-1:0]    mem_we_s;
    logic [XLEN-1:0]          mem_wdata_s;
    logic                     rd_s;

    logic                     ocd_rvalid_s;
    logic                     code_rvalid_s;
    logic                     data_rvalid_s;
    logic [XLEN-1:0]          rdata_s;

    // ------------------------------------------------------------------
    // Halt handshake FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic. DRAIN leaves as soon as no read is awaiting return,
    // so with nothing outstanding it lasts a single cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (bus.ocd_halt) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!bus.ocd_halt) begin
                    state_nx_s = ST_RUN;
                end else if (owner_r == OWNER_NONE) begin
                    state_nx_s = ST_HALTED;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                if (bus.ocd_halt) begin
                    state_nx_s = ST_HALTED;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
    end

    // State decode. Core grants stop in the very cycle ocd_halt rises;
    // the ack follows the HALTED state register and is masked in reset.
    always_comb begin
        run_s      = 1'b0;
        core_en_s  = 1'b0;
        halt_ack_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                run_s     = 1'b1;
                core_en_s = !bus.ocd_halt;
            end
            ST_DRAIN: begin
                run_s     = 1'b0;
                core_en_s = 1'b0;
            end
            ST_HALTED: begin
                halt_ack_s = !sync_reset;
            end
            default: begin
                run_s      = 1'b0;
                core_en_s  = 1'b0;
                halt_ack_s = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Winner selection: OCD first, then data over code unless only code
    // has been promoted by its wait counter.
    always_comb begin
        win_s = OWNER_NONE;
        if (sync_reset) begin
            win_s = OWNER_NONE;
        end else if (bus.ocd_req) begin
            win_s = OWNER_OCD;
        end else if (core_en_s && bus.code_req && bus.data_req) begin
            if (code_sat_s && !data_sat_s) begin
                win_s = OWNER_CODE;
            end else begin
                win_s = OWNER_DATA;
            end
        end else if (core_en_s && bus.data_req) begin
            win_s = OWNER_DATA;
        end else if (core_en_s && bus.code_req) begin
            win_s = OWNER_CODE;
        end else begin
            win_s = OWNER_NONE;
        end
    end

    assign ocd_gnt_s  = (win_s == OWNER_OCD);
    assign code_gnt_s = (win_s == OWNER_CODE);
    assign data_gnt_s = (win_s == OWNER_DATA);

    // Denied cycles only accumulate in RUN; outside RUN they hold.
    assign code_inc_s = bus.code_req && !code_gnt_s && run_s;
    assign code_clr_s = code_gnt_s || !bus.code_req;
    assign data_inc_s = bus.data_req && !data_gnt_s && run_s;
    assign data_clr_s = data_gnt_s || !bus.data_req;

    rv2t_mem_arbiter_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_code_wait (
        .clk        (clk),
        .sync_reset (sync_reset),
        .inc        (code_inc_s),
        .clr        (code_clr_s),
        .saturated  (code_sat_s)
    );

    rv2t_mem_arbiter_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_data_wait (
        .clk        (clk),
        .sync_reset (sync_reset),
        .inc        (data_inc_s),
        .clr        (data_clr_s),
        .saturated  (data_sat_s)
    );

    // Memory port mux. With no winner the data address is presented as a
    // harmless read and nothing is written.
    always_comb begin
        mem_addr_s  = bus.data_addr;
        mem_we_s    = {XLEN_BYTES{1'b0}};
        mem_wdata_s = bus.data_wdata;
        rd_s        = 1'b0;
        case (win_s)
            OWNER_OCD: begin
                mem_addr_s  = bus.ocd_addr;
                mem_we_s    = bus.ocd_we ? {XLEN_BYTES{1'b1}} : {XLEN_BYTES{1'b0}};
                mem_wdata_s = bus.ocd_wdata;
                rd_s        = !bus.ocd_we;
            end
            OWNER_CODE: begin
                mem_addr_s  = bus.code_addr;
                mem_we_s    = {XLEN_BYTES{1'b0}};
                mem_wdata_s = {XLEN{1'b0}};
                rd_s        = 1'b1;
            end
            OWNER_DATA: begin
                mem_addr_s  = bus.data_addr;
                mem_we_s    = bus.data_be;
                mem_wdata_s = bus.data_wdata;
                rd_s        = is_read_be(bus.data_be);
            end
            default: begin
                mem_addr_s  = bus.data_addr;
                mem_we_s    = {XLEN_BYTES{1'b0}};
                mem_wdata_s = bus.data_wdata;
                rd_s        = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read return routing
    // ------------------------------------------------------------------

    // Only reads leave an owner behind; writes return nothing.
    always_comb begin
        if (rd_s) begin
            owner_nx_s = win_s;
        end else begin
            owner_nx_s = OWNER_NONE;
        end
    end

    // Read-owner register: who receives next cycle's mem_read_data.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            owner_r <= OWNER_NONE;
        end else begin
            owner_r <= owner_nx_s;
        end
    end

    // Owner decode; masked in reset so a read caught by reset never shows
    // up as rvalid.
    always_comb begin
        ocd_rvalid_s  = 1'b0;
        code_rvalid_s = 1'b0;
        data_rvalid_s = 1'b0;
        if (sync_reset) begin
            ocd_rvalid_s  = 1'b0;
            code_rvalid_s = 1'b0;
            data_rvalid_s = 1'b0;
        end else begin
            case (owner_r)
                OWNER_OCD:  ocd_rvalid_s  = 1'b1;
                OWNER_CODE: code_rvalid_s = 1'b1;
                OWNER_DATA: data_rvalid_s = 1'b1;
                default: begin
                    ocd_rvalid_s  = 1'b0;
                    code_rvalid_s = 1'b0;
                    data_rvalid_s = 1'b0;
                end
            endcase
        end
    end

    // Shared return word is forced to zero when nobody owns it.
    always_comb begin
        if (ocd_rvalid_s || code_rvalid_s || data_rvalid_s) begin
            rdata_s = bus.mem_read_data;
        end else begin
            rdata_s = {XLEN{1'b0}};
        end
    end

    assign bus.ocd_gnt        = ocd_gnt_s;
    assign bus.code_gnt       = code_gnt_s;
    assign bus.data_gnt       = data_gnt_s;
    assign bus.ocd_rvalid     = ocd_rvalid_s;
    assign bus.code_rvalid    = code_rvalid_s;
    assign bus.data_rvalid    = data_rvalid_s;
    assign bus.rdata          = rdata_s;
    assign bus.ocd_halt_ack   = halt_ack_s;
    assign bus.mem_addr       = mem_addr_s;
    assign bus.mem_write_en   = mem_we_s;
    assign bus.mem_write_data = mem_wdata_s;

endmodule

// File: tb/tb_rv2t_mem_arbiter.sv
// tb_rv2t_mem_arbiter
// Self-checking bench: scenario tasks check grants and memory-port values
// inline and push expected read returns into a scoreboard queue that a
// monitor pops whenever an rvalid appears.
module tb_rv2t_mem_arbiter;
    import rv2t_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic sync_reset;

    always #5 clk = ~clk;

    rv2t_mem_arbiter_if bus_if();

    rv2t_mem_arbiter #(
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [2:0]  vec;   // {ocd, code, data} rvalid expected
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    // Reference contents every word holds after reset.
    function automatic logic [31:0] init_word(input int idx);
        logic [7:0] b;
        b = idx[7:0];
        return {b ^ 8'hC3, b, ~b, 8'h5A};
    endfunction

    // Memory model: reloads on reset, per-lane writes, 1-cycle read latency.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (sync_reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else begin
            for (int l = 0; l < 4; l++)
                if (bus_if.mem_write_en[l])
                    mem[bus_if.mem_addr[7:0]][l*8 +: 8] <= bus_if.mem_write_data[l*8 +: 8];
        end
        bus_if.mem_read_data <= mem[bus_if.mem_addr[7:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] gv();
        return {bus_if.ocd_gnt, bus_if.code_gnt, bus_if.data_gnt};
    endfunction

    function automatic logic [2:0] rv();
        return {bus_if.ocd_rvalid, bus_if.code_rvalid, bus_if.data_rvalid};
    endfunction

    task automatic push_exp(input logic [2:0] vec, input logic [31:0] data);
        exp_t e;
        e.vec  = vec;
        e.data = data;
        e.due  = cyc + 1;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every rvalid must match the oldest expected return.
    always @(negedge clk) begin
        logic [2:0] obs;
        exp_t       e;
        #2;
        obs = rv();
        if ((|obs) === 1'b1) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL rvalid_unexpected: rvalid=%b rdata=%h expected none", obs, bus_if.rdata);
            end else begin
                e = sb_q.pop_front();
                if (obs !== e.vec || bus_if.rdata !== e.data || e.due != cyc)
                    $display("FAIL read_return: rvalid=%b rdata=%h cyc=%0d expected rvalid=%b rdata=%h cyc=%0d",
                             obs, bus_if.rdata, cyc, e.vec, e.data, e.due);
                else
                    n_pass++;
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            n_total++;
            e = sb_q.pop_front();
            $display("FAIL read_missing: rvalid=%b expected rvalid=%b rdata=%h", obs, e.vec, e.data);
        end
    end

    task automatic idle();
        bus_if.ocd_req    = 1'b0;
        bus_if.ocd_we     = 1'b0;
        bus_if.code_req   = 1'b0;
        bus_if.data_req   = 1'b0;
        bus_if.data_be    = 4'h0;
    endtask

    task automatic test_reset();
        sync_reset         = 1'b1;
        bus_if.code_req    = 1'b1;
        bus_if.data_req    = 1'b1;
        bus_if.data_be     = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (gv() !== 3'b000) $display("FAIL rst_gnt: gnt=%b expected 000", gv()); else n_pass++;
        n_total++; if (rv() !== 3'b000) $display("FAIL rst_rvalid: rvalid=%b expected 000", rv()); else n_pass++;
        n_total++; if (bus_if.mem_write_en !== 4'h0) $display("FAIL rst_we: we=%h expected 0", bus_if.mem_write_en); else n_pass++;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b0) $display("FAIL rst_ack: ack=%b expected 0", bus_if.ocd_halt_ack); else n_pass++;
        @(negedge clk);
        sync_reset       = 1'b0;
        idle();
        bus_if.data_addr = 16'h0077;
        #1;
        n_total++; if (gv() !== 3'b000) $display("FAIL idle_gnt: gnt=%b expected 000", gv()); else n_pass++;
        n_total++; if (bus_if.mem_write_en !== 4'h0) $display("FAIL idle_we: we=%h expected 0", bus_if.mem_write_en); else n_pass++;
        n_total++; if (bus_if.mem_addr !== 16'h0077) $display("FAIL idle_addr: addr=%h expected 0077", bus_if.mem_addr); else n_pass++;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b0) $display("FAIL idle_ack: ack=%b expected 0", bus_if.ocd_halt_ack); else n_pass++;
    endtask

    task automatic test_data_over_code();
        @(negedge clk);
        bus_if.code_req  = 1'b1;
        bus_if.code_addr = 16'h0040;
        bus_if.data_req  = 1'b1;
        bus_if.data_be   = 4'h0;
        bus_if.data_addr = 16'h0010;
        #1;
        n_total++; if (gv() !== 3'b001) $display("FAIL dc_gnt_data: gnt=%b expected 001", gv()); else n_pass++;
        n_total++; if (bus_if.mem_addr !== 16'h0010) $display("FAIL dc_addr: addr=%h expected 0010", bus_if.mem_addr); else n_pass++;
        n_total++; if (bus_if.mem_write_en !== 4'h0) $display("FAIL dc_we: we=%h expected 0", bus_if.mem_write_en); else n_pass++;
        push_exp(3'b001, init_word(16'h0010));
        @(negedge clk);
        bus_if.data_req = 1'b0;
        #1;
        n_total++; if (gv() !== 3'b010) $display("FAIL dc_gnt_code: gnt=%b expected 010", gv()); else n_pass++;
        n_total++; if (bus_if.mem_addr !== 16'h0040) $display("FAIL dc_code_addr: addr=%h expected 0040", bus_if.mem_addr); else n_pass++;
        push_exp(3'b010, init_word(16'h0040));
        @(negedge clk);
        bus_if.code_req = 1'b0;
        #1;
        n_total++; if (gv() !== 3'b000) $display("FAIL dc_gnt_idle: gnt=%b expected 000", gv()); else n_pass++;
    endtask

    task automatic test_promotion();
        @(negedge clk);
        bus_if.data_req  = 1'b1;
        bus_if.data_be   = 4'hF;
        bus_if.data_addr = 16'h0030;
        bus_if.code_req  = 1'b1;
        bus_if.code_addr = 16'h0044;
        for (int i = 0; i < 4; i++) begin
            bus_if.data_wdata = 32'h1111_0000 + 32'(i);
            #1;
            n_total++; if (gv() !== 3'b001) $display("FAIL promo_wait%0d: gnt=%b expected 001", i, gv()); else n_pass++;
            n_total++; if (bus_if.mem_write_en !== 4'hF) $display("FAIL promo_we%0d: we=%h expected F", i, bus_if.mem_write_en); else n_pass++;
            @(negedge clk);
        end
        bus_if.data_wdata = 32'h2222_2222;
        #1;
        n_total++; if (gv() !== 3'b010) $display("FAIL promo_code: gnt=%b expected 010", gv()); else n_pass++;
        n_total++; if (bus_if.mem_write_en !== 4'h0) $display("FAIL promo_code_we: we=%h expected 0", bus_if.mem_write_en); else n_pass++;
        n_total++; if (bus_if.mem_addr !== 16'h0044) $display("FAIL promo_code_addr: addr=%h expected 0044", bus_if.mem_addr); else n_pass++;
        push_exp(3'b010, init_word(16'h0044));
        @(negedge clk);
        bus_if.code_req   = 1'b0;
        bus_if.data_wdata = 32'hDEAD_BEEF;
        #1;
        n_total++; if (gv() !== 3'b001) $display("FAIL promo_resume: gnt=%b expected 001", gv()); else n_pass++;
        n_total++; if (bus_if.mem_write_data !== 32'hDEAD_BEEF) $display("FAIL promo_wdata: wdata=%h expected deadbeef", bus_if.mem_write_data); else n_pass++;
        @(negedge clk);
        bus_if.data_be = 4'h0;
        #1;
        n_total++; if (gv() !== 3'b001) $display("FAIL promo_readback_gnt: gnt=%b expected 001", gv()); else n_pass++;
        push_exp(3'b001, 32'hDEAD_BEEF);
        @(negedge clk);
        bus_if.data_req = 1'b0;
    endtask

    task automatic test_ocd_priority();
        @(negedge clk);
        bus_if.ocd_req   = 1'b1;
        bus_if.ocd_we    = 1'b0;
        bus_if.ocd_addr  = 16'h0020;
        bus_if.data_req  = 1'b1;
        bus_if.data_be   = 4'h0;
        bus_if.data_addr = 16'h0011;
        bus_if.code_req  = 1'b1;
        bus_if.code_addr = 16'h0048;
        #1;
        n_total++; if (gv() !== 3'b100) $display("FAIL ocd_gnt_rd: gnt=%b expected 100", gv()); else n_pass++;
        n_total++; if (bus_if.mem_addr !== 16'h0020) $display("FAIL ocd_addr: addr=%h expected 0020", bus_if.mem_addr); else n_pass++;
        push_exp(3'b100, init_word(16'h0020));
        @(negedge clk);
        bus_if.ocd_we    = 1'b1;
        bus_if.ocd_addr  = 16'h0021;
        bus_if.ocd_wdata = 32'hCAFE_F00D;
        #1;
        n_total++; if (gv() !== 3'b100) $display("FAIL ocd_gnt_wr: gnt=%b expected 100", gv()); else n_pass++;
        n_total++; if (bus_if.mem_write_en !== 4'hF) $display("FAIL ocd_we: we=%h expected F", bus_if.mem_write_en); else n_pass++;
        n_total++; if (bus_if.mem_write_data !== 32'hCAFE_F00D) $display("FAIL ocd_wdata: wdata=%h expected cafef00d", bus_if.mem_write_data); else n_pass++;
        @(negedge clk);
        bus_if.ocd_req = 1'b0;
        bus_if.ocd_we  = 1'b0;
        #1;
        n_total++; if (gv() !== 3'b001) $display("FAIL ocd_after_data: gnt=%b expected 001", gv()); else n_pass++;
        push_exp(3'b001, init_word(16'h0011));
        @(negedge clk);
        bus_if.data_req = 1'b0;
        bus_if.ocd_req  = 1'b1;
        bus_if.ocd_addr = 16'h0021;
        #1;
        n_total++; if (gv() !== 3'b100) $display("FAIL ocd_readback_gnt: gnt=%b expected 100", gv()); else n_pass++;
        push_exp(3'b100, 32'hCAFE_F00D);
        @(negedge clk);
        bus_if.ocd_req = 1'b0;
        #1;
        n_total++; if (gv() !== 3'b010) $display("FAIL ocd_after_code: gnt=%b expected 010", gv()); else n_pass++;
        push_exp(3'b010, init_word(16'h0048));
        @(negedge clk);
        bus_if.code_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] iw;
        @(negedge clk);
        bus_if.data_req = 1'b1;
        bus_if.data_be  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            bus_if.data_addr = 16'h0060 + 16'(i);
            #1;
            n_total++; if (gv() !== 3'b001) $display("FAIL b2b_gnt%0d: gnt=%b expected 001", i, gv()); else n_pass++;
            push_exp(3'b001, init_word(16'h0060 + i));
            @(negedge clk);
        end
        bus_if.data_addr  = 16'h0031;
        bus_if.data_be    = 4'b0101;
        bus_if.data_wdata = 32'h1234_5678;
        #1;
        n_total++; if (bus_if.mem_write_en !== 4'b0101) $display("FAIL b2b_partial_we: we=%b expected 0101", bus_if.mem_write_en); else n_pass++;
        @(negedge clk);
        bus_if.data_be = 4'h0;
        #1;
        n_total++; if (gv() !== 3'b001) $display("FAIL b2b_readback_gnt: gnt=%b expected 001", gv()); else n_pass++;
        iw = init_word(16'h0031);
        push_exp(3'b001, {iw[31:24], 8'h34, iw[15:8], 8'h78});
        @(negedge clk);
        bus_if.data_req = 1'b0;
    endtask

    task automatic test_halt();
        @(negedge clk);
        bus_if.code_req  = 1'b1;
        bus_if.code_addr = 16'h0050;
        #1;
        n_total++; if (gv() !== 3'b010) $display("FAIL halt_pre_gnt: gnt=%b expected 010", gv()); else n_pass++;
        push_exp(3'b010, init_word(16'h0050));
        @(negedge clk);
        bus_if.ocd_halt  = 1'b1;
        bus_if.code_addr = 16'h0054;
        #1;
        n_total++; if (gv() !== 3'b000) $display("FAIL halt_req_gnt: gnt=%b expected 000", gv()); else n_pass++;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b0) $display("FAIL halt_ack_c0: ack=%b expected 0", bus_if.ocd_halt_ack); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (gv() !== 3'b000) $display("FAIL halt_drain_gnt: gnt=%b expected 000", gv()); else n_pass++;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b0) $display("FAIL halt_ack_c1: ack=%b expected 0", bus_if.ocd_halt_ack); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (gv() !== 3'b000) $display("FAIL halted_gnt: gnt=%b expected 000", gv()); else n_pass++;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b1) $display("FAIL halt_ack_c2: ack=%b expected 1", bus_if.ocd_halt_ack); else n_pass++;
        @(negedge clk);
        bus_if.ocd_req  = 1'b1;
        bus_if.ocd_we   = 1'b0;
        bus_if.ocd_addr = 16'h0022;
        #1;
        n_total++; if (gv() !== 3'b100) $display("FAIL halted_ocd_gnt: gnt=%b expected 100", gv()); else n_pass++;
        push_exp(3'b100, init_word(16'h0022));
        @(negedge clk);
        bus_if.ocd_req  = 1'b0;
        bus_if.ocd_halt = 1'b0;
        #1;
        n_total++; if (gv() !== 3'b000) $display("FAIL unhalt_gnt: gnt=%b expected 000", gv()); else n_pass++;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b1) $display("FAIL unhalt_ack: ack=%b expected 1", bus_if.ocd_halt_ack); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b0) $display("FAIL run_ack: ack=%b expected 0", bus_if.ocd_halt_ack); else n_pass++;
        n_total++; if (gv() !== 3'b010) $display("FAIL run_code_gnt: gnt=%b expected 010", gv()); else n_pass++;
        push_exp(3'b010, init_word(16'h0054));
        @(negedge clk);
        bus_if.code_req = 1'b0;
    endtask

    task automatic test_reset_kills_read();
        @(negedge clk);
        bus_if.data_req  = 1'b1;
        bus_if.data_be   = 4'h0;
        bus_if.data_addr = 16'h0012;
        #1;
        n_total++; if (gv() !== 3'b001) $display("FAIL rk_gnt: gnt=%b expected 001", gv()); else n_pass++;
        @(negedge clk);
        bus_if.data_req = 1'b0;
        bus_if.code_req = 1'b1;
        sync_reset      = 1'b1;
        #1;
        n_total++; if (rv() !== 3'b000) $display("FAIL rk_rvalid: rvalid=%b expected 000", rv()); else n_pass++;
        n_total++; if (gv() !== 3'b000) $display("FAIL rk_gnt_rst: gnt=%b expected 000", gv()); else n_pass++;
        n_total++; if (bus_if.rdata !== 32'h0) $display("FAIL rk_rdata: rdata=%h expected 0", bus_if.rdata); else n_pass++;
        n_total++; if (bus_if.mem_write_en !== 4'h0) $display("FAIL rk_we: we=%h expected 0", bus_if.mem_write_en); else n_pass++;
        n_total++; if (bus_if.ocd_halt_ack !== 1'b0) $display("FAIL rk_ack: ack=%b expected 0", bus_if.ocd_halt_ack); else n_pass++;
        @(negedge clk);
        sync_reset      = 1'b0;
        bus_if.code_req = 1'b0;
        #1;
        n_total++; if (rv() !== 3'b000) $display("FAIL rk_rvalid_post: rvalid=%b expected 000", rv()); else n_pass++;
        n_total++; if (gv() !== 3'b000) $display("FAIL rk_gnt_post: gnt=%b expected 000", gv()); else n_pass++;
    endtask

    initial begin
        sync_reset        = 1'b1;
        bus_if.ocd_req    = 1'b0;
        bus_if.ocd_we     = 1'b0;
        bus_if.ocd_addr   = 16'h0000;
        bus_if.ocd_wdata  = 32'h0;
        bus_if.ocd_halt   = 1'b0;
        bus_if.code_req   = 1'b0;
        bus_if.code_addr  = 16'h0000;
        bus_if.data_req   = 1'b0;
        bus_if.data_be    = 4'h0;
        bus_if.data_addr  = 16'h0000;
        bus_if.data_wdata = 32'h0;

        test_reset();
        test_data_over_code();
        test_promotion();
        test_ocd_priority();
        test_back_to_back();
        test_halt();
        test_reset_kills_read();

        repeat (3) @(negedge clk);
        #3;
        n_total++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: pending=%0d expected 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
